// File: rtl/seg_pkg.sv
// Seven-segment glyph constants for the multiplexed hex display.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry n holds the glyph for hex digit n
   localparam logic [15:0][6:0] GLYPH_TAB = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      return GLYPH_TAB[nib];
   endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Button, channel data and display signals of the scanned display.
interface seg_scan_mux_if #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned NUM_DIGITS = 8
);
   localparam int unsigned CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

   logic                    btn;
   logic [NUM_CH*32-1:0]    ch_data;
   logic [CW-1:0]           ch_sel;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    dp;

   modport master (output btn, output ch_data,
                   input  ch_sel, input seg, input an, input dp);
   modport slave  (input  btn, input ch_data,
                   output ch_sel, output seg, output an, output dp);
endinterface

// File: rtl/btn_debounce.sv
// Synchronises a raw pushbutton, debounces it and flags accepted rising edges.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise_pulse
);
   localparam int unsigned CNTW = $clog2(DB_CYCLES);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            level_q, level_d;
   logic            rise_q,  rise_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;

   // Any sample agreeing with the accepted level restarts the count
   always_comb begin : db_next
      sync1_d = btn;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNTW'(DB_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end
      rise_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or posedge rst) begin : db_regs
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Channel-selectable 32-bit hex value shown on a scanned seven-segment display.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned DB_CYCLES  = 1000000,
   parameter int unsigned BLANK_LZ   = 1
) (
   input  logic          clk,
   input  logic          rst,
   seg_scan_mux_if.slave bus
);
   localparam int unsigned CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned DW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned TW = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;

   logic                  btn_level, btn_rise, adv;
   logic [CW-1:0]         ch_sel_q, ch_sel_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [DW-1:0]         dig_q, dig_d;
   logic [31:0]           disp_q, disp_d;
   logic                  load_q, load_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  dp_q, dp_d;

   logic [31:0]           ch_word [NUM_CH];
   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lz_zero;
   logic                  all_zero;
   logic                  blank;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk        (clk),
      .rst        (rst),
      .btn        (bus.btn),
      .level      (btn_level),
      .rise_pulse (btn_rise)
   );

   // The rise pulse always coincides with the newly accepted high level
   assign adv = btn_rise & btn_level;

   // lz_zero[i]: nibbles i..NUM_DIGITS-1 of the frame are all zero
   always_comb begin : unpack
      for (int k = 0; k < int'(NUM_CH); k++) begin
         ch_word[k] = bus.ch_data[32*k +: 32];
      end
      all_zero = 1'b1;
      lz_zero  = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         nib[i]     = disp_q[4*i +: 4];
         all_zero   = all_zero & (nib[i] == 4'h0);
         lz_zero[i] = all_zero;
      end
   end

   // Post-reset load first, then channel change, then the slot timer
   always_comb begin : scan_next
      ch_sel_d = ch_sel_q;
      tick_d   = tick_q + TW'(1);
      dig_d    = dig_q;
      disp_d   = disp_q;
      load_d   = 1'b0;
      if (load_q) begin
         tick_d = '0;
         dig_d  = '0;
         disp_d = ch_word[ch_sel_q];
      end else if (adv) begin
         ch_sel_d = (ch_sel_q == CW'(NUM_CH - 1)) ? '0 : ch_sel_q + CW'(1);
         tick_d   = '0;
         dig_d    = '0;
         disp_d   = ch_word[ch_sel_d];
      end else if (tick_q == TW'(SCAN_DIV - 1)) begin
         tick_d = '0;
         dig_d  = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
         if (dig_d == '0) begin
            disp_d = ch_word[ch_sel_q];
         end
      end
   end

   always_comb begin : disp_decode
      blank = (BLANK_LZ != 0) && (dig_q != '0) && lz_zero[dig_q];
      seg_d = blank ? SEG_BLANK : hex_glyph(nib[dig_q]);
      an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << dig_q);
      dp_d  = !((32'(ch_sel_q) < NUM_DIGITS) && (32'(dig_q) == 32'(ch_sel_q)));
   end

   always_ff @(posedge clk or posedge rst) begin : regs
      if (rst) begin
         ch_sel_q <= '0;
         tick_q   <= '0;
         dig_q    <= '0;
         disp_q   <= '0;
         load_q   <= 1'b1;
         seg_q    <= SEG_BLANK;
         an_q     <= '1;
         dp_q     <= 1'b1;
      end else begin
         ch_sel_q <= ch_sel_d;
         tick_q   <= tick_d;
         dig_q    <= dig_d;
         disp_q   <= disp_d;
         load_q   <= load_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         dp_q     <= dp_d;
      end
   end

   assign bus.ch_sel = ch_sel_q;
   assign bus.seg    = seg_q;
   assign bus.an     = an_q;
   assign bus.dp     = dp_q;

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4: number of 32-bit source channels, legal range 2..8.
REQ-002 The module SHALL have parameter NUM_DIGITS, default 8: number of seven-segment digits, legal range 1..8.
REQ-003 The module SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot, minimum 2.
REQ-004 The module SHALL have parameter DB_CYCLES, default 1000000: consecutive stable samples needed to accept a button level, minimum 2.
REQ-005 The module SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single system clock.
REQ-007 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-008 Port btn SHALL be an input, 1 bit wide: raw, asynchronous channel-advance pushbutton.
REQ-009 Port ch_data SHALL be an input, NUM_CH*32 bits wide: channel k occupies bits [32k+31:32k].
REQ-010 Port ch_sel SHALL be an output, CW = max(1, clog2(NUM_CH)) bits wide: the currently selected channel.
REQ-011 Port seg SHALL be an output, 7 bits wide, active-low, ordered {g,f,e,d,c,b,a}.
REQ-012 Port an SHALL be an output, NUM_DIGITS bits wide, active-low digit enables.
REQ-013 Port dp SHALL be an output, 1 bit wide, active-low decimal point.

Function
REQ-014 The module SHALL pass btn through a two-flop synchroniser before any other use.
REQ-015 The debounced level SHALL take the synchronised value only after that value has differed from the current debounced level for DB_CYCLES consecutive cycles; any shorter excursion SHALL restart the count.
REQ-016 On a debounced 0->1 transition, ch_sel SHALL increment by 1 in the following cycle, wrapping from NUM_CH-1 to 0; a 1->0 transition SHALL have no effect.
REQ-017 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, the digit index SHALL increment, wrapping from NUM_DIGITS-1 to 0.
REQ-018 The display register disp_q (32 bits) SHALL load ch_data of channel ch_sel whenever the digit index advances to 0, so that no frame mixes data from two samples.
REQ-019 When ch_sel changes, the same cycle SHALL clear the tick counter and the digit index to 0 and load disp_q from the new channel; this takes priority over a simultaneous tick wrap.
REQ-020 seg, an and dp SHALL be registered and SHALL reflect the digit index one cycle after the index updates.
REQ-021 Digit i SHALL display nibble disp_q[4i+3:4i] as a hex glyph 0-F; digit 0 is the rightmost digit.
REQ-022 an SHALL drive exactly one bit low, the bit at the digit index, except when that digit is blanked.
REQ-023 With BLANK_LZ=1, digit i>0 SHALL be blanked (an all ones, seg 7'h7F) when all nibbles i..NUM_DIGITS-1 are zero; digit 0 SHALL never be blanked.
REQ-024 dp SHALL be 0 while the digit index equals ch_sel (channel indicator) and 1 otherwise; when ch_sel >= NUM_DIGITS, dp SHALL stay 1.
REQ-025 ch_data changes in the middle of a frame SHALL NOT alter the displayed glyphs until the next frame load.

Reset
REQ-026 While rst=1, all registers SHALL take their reset values asynchronously: ch_sel=0, disp_q=0, digit index=0, tick=0, debounce count=0, debounced level=0, synchroniser=0.
REQ-027 While rst=1, the outputs SHALL be seg=7'h7F, an all ones, and dp=1.
REQ-028 After rst deasserts, the first digit slot SHALL show digit 0 of channel 0, loaded on the first cycle.
REQ-029 A button press in progress when rst asserts SHALL be discarded.

Structure
REQ-030 The package seg_pkg SHALL hold the 16-entry hex-to-segment glyph constants and the blank pattern 7'h7F.
REQ-031 Debounce and edge detection SHALL be a separate sub-module, btn_debounce, with parameter DB_CYCLES and outputs level and rise_pulse.
REQ-032 The scan logic, the channel mux and glyph decode SHALL remain in seg_scan_mux.

Verification (NUM_CH=3, NUM_DIGITS=4, SCAN_DIV=4, DB_CYCLES=8 unless stated)
REQ-033 Scenario: ch_data ch0=32'h0000_1A3F, no press -> an cycles 1110,1101,1011,0111, each for 4 cycles; seg shows F,3,A,1; dp=0 only in the digit-0 slot.
REQ-034 Scenario: ch0=32'h0000_0005, BLANK_LZ=1 -> only digit 0 is lit, showing glyph 5; digits 1-3 have an all ones; with BLANK_LZ=0, the display shows 0005.
REQ-035 Scenario: three clean presses, each held 20 cycles -> ch_sel goes 1,2,0; after each change, the scan restarts at digit 0 with the new channel data; the dp indicator moves to digit 1, then 2, then 0.
REQ-036 Scenario: btn glitches of 1..7 cycles, then a 10-cycle press -> exactly one increment of ch_sel.
REQ-037 Scenario: change ch0 from 32'h1111 to 32'h2222 during digit 2 of a frame -> the remaining digits of that frame still show 1; the next frame shows 2.
REQ-038 Scenario: assert rst in the middle of a frame with ch_sel=2 -> seg=7'h7F, an=1111 and dp=1 immediately, without waiting for a clock edge; after release, ch_sel=0 and the digit-0 slot shows ch0.
